// File: rtl/mop_thread_sched.sv
// mop_thread_sched
// Interleaves up to N_THR micro-op threads onto a single multiplier issue port.
// Each thread walks its pc from start_pc to end_pc inclusive (modulo 2^PC_W). It
// then waits LAT cycles for its last result to leave the pipeline, pulses done
// and returns to IDLE.
// Build option: define SCHED_SKIP_IDLE_EN for work-conserving round-robin
// arbitration. Without it, each thread owns a fixed TDM slot.
module mop_thread_sched #(
  parameter int N_THR = 5,
  parameter int LAT   = 76,
  parameter int PC_W  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [$clog2(N_THR)-1:0] start_thr,
  input  logic [PC_W-1:0]          start_pc,
  input  logic [PC_W-1:0]          end_pc,
  input  logic                     stall,
  output logic                     issue_valid,
  output logic [$clog2(N_THR)-1:0] issue_thr,
  output logic [PC_W-1:0]          issue_pc,
  output logic [N_THR-1:0]         done,
  output logic                     err,
  output logic                     busy
);
  localparam int TW = $clog2(N_THR);
  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_W = CW'(LAT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} thr_state_t;

  logic [N_THR-1:0] run_vec;
  logic [N_THR-1:0] idle_vec;
  logic [N_THR-1:0] start_hit_vec;
  logic [PC_W-1:0]  pc_all [N_THR];

  logic             grant_valid;
  logic [TW-1:0]    grant_thr;
  logic [TW-1:0]    slot_reg, slot_next;

  logic             issue_valid_reg;
  logic [TW-1:0]    issue_thr_reg;
  logic [PC_W-1:0]  issue_pc_reg;
  logic             err_reg, err_next;

`ifdef SCHED_SKIP_IDLE_EN
  localparam logic [TW:0] N_THR_W = (TW + 1)'(N_THR);
  logic [TW:0] cand;

  // Round-robin: grant the first RUN thread after the last granted one.
  // slot_reg remembers that last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_thr   = slot_reg;
    cand        = '0;
    for (int k = 1; k <= N_THR; k++) begin
      cand = {1'b0, slot_reg} + (TW + 1)'(k);
      if (cand >= N_THR_W) cand = cand - N_THR_W;
      if (!stall && !grant_valid && run_vec[cand[TW-1:0]]) begin
        grant_valid = 1'b1;
        grant_thr   = cand[TW-1:0];
      end
    end
    slot_next = grant_valid ? grant_thr : slot_reg;
  end
`else
  localparam logic [TW-1:0] LAST_SLOT = TW'(N_THR - 1);

  // Fixed TDM: the slot owner issues only if it is running. The slot advances
  // on every unstalled cycle, even when the slot is empty.
  always_comb begin
    grant_valid = !stall && run_vec[slot_reg];
    grant_thr   = slot_reg;
    if (stall)                   slot_next = slot_reg;
    else if (slot_reg == LAST_SLOT) slot_next = '0;
    else                         slot_next = slot_reg + TW'(1);
  end
`endif

  // A start is rejected unless it targets an existing thread that is idle now.
  // A thread that is pulsing done is still DRAIN in that cycle.
  assign err_next = start && ~|(start_hit_vec & idle_vec);

  // Slot pointer, registered issue port and error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_reg        <= '0;
      issue_valid_reg <= 1'b0;
      issue_thr_reg   <= '0;
      issue_pc_reg    <= '0;
      err_reg         <= 1'b0;
    end else begin
      slot_reg        <= slot_next;
      issue_valid_reg <= grant_valid;
      if (grant_valid) begin
        issue_thr_reg <= grant_thr;
        issue_pc_reg  <= pc_all[grant_thr];
      end
      err_reg         <= err_next;
    end
  end

  for (genvar gi = 0; gi < N_THR; gi++) begin : g_thr
    thr_state_t      state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] end_reg, end_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            start_hit, grant_hit;

    assign start_hit = start && (start_thr == TW'(gi));
    assign grant_hit = grant_valid && (grant_thr == TW'(gi));

    // Per-thread context registers.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_reg <= IDLE;
        pc_reg    <= '0;
        end_reg   <= '0;
        cnt_reg   <= '0;
      end else begin
        state_reg <= state_next;
        pc_reg    <= pc_next;
        end_reg   <= end_next;
        cnt_reg   <= cnt_next;
      end
    end

    // Thread FSM. It launches on start, steps pc on each grant, and drains LAT
    // cycles after its last issue. The drain count ignores stall.
    always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      end_next   = end_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
        IDLE: begin
          if (start_hit) begin
            state_next = RUN;
            pc_next    = start_pc;
            end_next   = end_pc;
          end
        end
        RUN: begin
          if (grant_hit) begin
            pc_next = pc_reg + PC_W'(1);
            if (pc_reg == end_reg) begin
              state_next = DRAIN;
              cnt_next   = LAT_W;
            end
          end
        end
        DRAIN: begin
          if (cnt_reg == '0) state_next = IDLE;
          else               cnt_next   = cnt_reg - CW'(1);
        end
        default: state_next = IDLE;
      endcase
    end

    assign run_vec[gi]       = (state_reg == RUN);
    assign idle_vec[gi]      = (state_reg == IDLE);
    assign start_hit_vec[gi] = start_hit;
    assign done[gi]          = (state_reg == DRAIN) && (cnt_reg == '0);
    assign pc_all[gi]        = pc_reg;
  end

  assign busy        = ~&idle_vec;
  assign issue_valid = issue_valid_reg;
  assign issue_thr   = issue_thr_reg;
  assign issue_pc    = issue_pc_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_mop_thread_sched.sv
// tb_mop_thread_sched
// Self-checking bench for mop_thread_sched at default parameters.
// A cycle-level reference model tracks each thread as idle, running or draining.
// Draining threads carry an absolute completion timestamp.
// Define SCHED_SKIP_IDLE_EN to check the round-robin build.
`timescale 1ns/1ps
module tb_mop_thread_sched;
  localparam int N_THR = 5;
  localparam int LAT   = 76;
  localparam int PC_W  = 8;
  localparam int TW    = $clog2(N_THR);
`ifdef SCHED_SKIP_IDLE_EN
  localparam int GAP = 1;
`else
  localparam int GAP = N_THR;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             start = 1'b0;
  logic [TW-1:0]    start_thr = '0;
  logic [PC_W-1:0]  start_pc = '0;
  logic [PC_W-1:0]  end_pc = '0;
  logic             stall = 1'b0;
  logic             issue_valid;
  logic [TW-1:0]    issue_thr;
  logic [PC_W-1:0]  issue_pc;
  logic [N_THR-1:0] done;
  logic             err;
  logic             busy;

  always #5 clk = ~clk;

  mop_thread_sched #(.N_THR(N_THR), .LAT(LAT), .PC_W(PC_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_thr(start_thr),
    .start_pc(start_pc), .end_pc(end_pc), .stall(stall),
    .issue_valid(issue_valid), .issue_thr(issue_thr), .issue_pc(issue_pc),
    .done(done), .err(err), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state.
  int m_state [N_THR];
  int m_pc [N_THR];
  int m_end [N_THR];
  int m_done_cyc [N_THR];
  int m_slot;
  int e_valid, e_thr, e_pc, e_err;

  typedef struct { int c; int thr; int pc; } ev_t;
  ev_t iss_q[$];
  ev_t done_q[$];

  typedef struct { logic s; int thr; int sp; int ep; logic exp_err; logic exp_busy; } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < N_THR; t++) begin
      m_state[t] = M_IDLE; m_pc[t] = 0; m_end[t] = 0; m_done_cyc[t] = -1;
    end
    m_slot = 0; e_valid = 0; e_thr = 0; e_pc = 0; e_err = 0;
  endtask

  // Advance the model by one clock, given this cycle's inputs.
  task automatic model_step(input logic s, input int th, input int sp, input int ep, input logic st);
    int g, nslot;
    logic accept;
    g = -1;
    nslot = m_slot;
    if (!st) begin
`ifdef SCHED_SKIP_IDLE_EN
      for (int k = 1; k <= N_THR; k++) begin
        int t;
        t = (m_slot + k) % N_THR;
        if (g < 0 && m_state[t] == M_RUN) g = t;
      end
      if (g >= 0) nslot = g;
`else
      if (m_state[m_slot] == M_RUN) g = m_slot;
      nslot = (m_slot + 1) % N_THR;
`endif
    end
    accept = s && (m_state[th] == M_IDLE);
    e_err = (s && !accept) ? 1 : 0;
    for (int t = 0; t < N_THR; t++)
      if (m_state[t] == M_DRAIN && m_done_cyc[t] == cyc) m_state[t] = M_IDLE;
    e_valid = (g >= 0) ? 1 : 0;
    if (g >= 0) begin
      e_thr = g;
      e_pc  = m_pc[g];
      if (m_pc[g] == m_end[g]) begin
        m_state[g] = M_DRAIN;
        m_done_cyc[g] = cyc + 1 + LAT;
      end
      m_pc[g] = (m_pc[g] + 1) % (1 << PC_W);
    end
    if (accept) begin
      m_state[th] = M_RUN; m_pc[th] = sp; m_end[th] = ep;
    end
    m_slot = nslot;
  endtask

  task automatic check_outputs();
    logic [N_THR-1:0] ed;
    int eb;
    ed = '0;
    eb = 0;
    for (int t = 0; t < N_THR; t++) begin
      if (m_state[t] == M_DRAIN && m_done_cyc[t] == cyc) ed[t] = 1'b1;
      if (m_state[t] != M_IDLE) eb = 1;
    end
    chk("issue_valid", 32'(issue_valid), e_valid);
    chk("issue_thr", 32'(issue_thr), e_thr);
    chk("issue_pc", 32'(issue_pc), e_pc);
    chk("err", 32'(err), e_err);
    chk("done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), eb);
  endtask

  // One clock: check the current outputs and log them, then drive the inputs
  // and advance the model.
  task automatic tick(input logic s, input int th, input int sp, input int ep, input logic st);
    check_outputs();
    if (issue_valid) iss_q.push_back('{cyc, int'(issue_thr), int'(issue_pc)});
    for (int t = 0; t < N_THR; t++) if (done[t]) done_q.push_back('{cyc, t, 0});
    start = s; start_thr = th[TW-1:0]; start_pc = sp[PC_W-1:0]; end_pc = ep[PC_W-1:0]; stall = st;
    model_step(s, th, sp, ep, st);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    start = 1'b0; stall = 1'b0; start_thr = '0; start_pc = '0; end_pc = '0;
    rstn = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_issue_thr", 32'(issue_thr), 0);
    chk("rst_issue_pc", 32'(issue_pc), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc += 3;
  endtask

  task automatic check_thread_seq(input string name, input int thr, input int first_pc, input int n);
    int k;
    k = 0;
    foreach (iss_q[i]) begin
      if (iss_q[i].thr == thr) begin
        chk(name, 32'(iss_q[i].pc), 32'((first_pc + k) % (1 << PC_W)));
        k++;
      end
    end
    chk({name, "_count"}, 32'(k), 32'(n));
  endtask

  function automatic int last_issue_cyc(input int thr);
    int c;
    c = -10000;
    foreach (iss_q[i]) if (iss_q[i].thr == thr) c = iss_q[i].c;
    return c;
  endfunction

  function automatic int done_cyc_of(input int thr);
    int c;
    c = -20000;
    foreach (done_q[i]) if (done_q[i].thr == thr) c = done_q[i].c;
    return c;
  endfunction

  initial begin
    #20ms;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, dcyc, s0, n, i3, d3;
    // start, thr, start_pc, end_pc, expected err next cycle, expected busy next cycle
    tbl[0] = '{1'b1, 0, 10, 20, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 0, 30, 40, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 3, 5, 6, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3, 7, 8, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 4, 0, 0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 0, 0, 0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 2, 1, 2, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 4, 9, 9, 1'b1, 1'b1};

    #2;
    do_reset();

    // Launch and reject table. Stall is held high, so threads stay RUN and nothing issues.
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].s, tbl[i].thr, tbl[i].sp, tbl[i].ep, 1'b1);
      chk("tbl_err", 32'(err), 32'(tbl[i].exp_err));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].exp_busy));
      chk("tbl_no_issue", 32'(issue_valid), 0);
      $display("vec %0d start=%0d thr=%0d err=%0d busy=%0d", i, tbl[i].s, tbl[i].thr, err, busy);
    end
    do_reset();

    // Thread 2 runs pc 10..12. Check the issue spacing and the drain timing,
    // then restart it in the same cycle its done pulses.
    iss_q.delete(); done_q.delete();
    c0 = cyc;
    tick(1'b1, 2, 10, 12, 1'b0);
    idle(3 * GAP + 4);
    chk("seq_count", 32'(iss_q.size()), 3);
    for (int i = 0; i < iss_q.size() && i < 3; i++) begin
      chk("seq_thr", 32'(iss_q[i].thr), 2);
      chk("seq_pc", 32'(iss_q[i].pc), 32'(10 + i));
      if (i > 0) chk("seq_gap", 32'(iss_q[i].c - iss_q[i-1].c), GAP);
      else       chk("seq_first_after_start", 32'(iss_q[i].c > c0), 1);
    end
    if (iss_q.size() == 3) begin
      dcyc = iss_q[2].c + LAT;
      for (int i = 0; i < 2 * LAT && cyc < dcyc; i++) idle(1);
      chk("done_at_lat", 32'(cyc), 32'(dcyc));
      chk("done_pulse", 32'(done), 32'h4);
      tick(1'b1, 2, 50, 50, 1'b0);
      chk("err_on_done_cycle", 32'(err), 1);
      tick(1'b1, 2, 50, 50, 1'b0);
      chk("start_after_done", 32'(err), 0);
    end
    idle(LAT + 2 * GAP + 10);
    $display("seq thr2 pc10..12 issues=%0d", iss_q.size());

    // pc wrap-around: 254, 255, 0, 1, then drain.
    iss_q.delete(); done_q.delete();
    tick(1'b1, 1, 254, 1, 1'b0);
    idle(4 * GAP + LAT + 8);
    check_thread_seq("wrap_pc", 1, 254, 4);
    chk("wrap_done_lat", 32'(done_cyc_of(1) - last_issue_cyc(1)), LAT);
    $display("wrap thr1 issues=%0d", iss_q.size());

    // A start to a running thread is rejected and leaves its sequence untouched.
    iss_q.delete(); done_q.delete();
    tick(1'b1, 1, 0, 3, 1'b0);
    idle(1);
    tick(1'b1, 1, 100, 110, 1'b0);
    chk("reject_err", 32'(err), 1);
    idle(1);
    chk("reject_err_one_cycle", 32'(err), 0);
    idle(4 * GAP + LAT + 8);
    check_thread_seq("reject_seq", 1, 0, 4);
    $display("reject thr1 issues=%0d", iss_q.size());

    // Stall for 10 cycles while thread 0 is mid-sequence and thread 3 drains.
    iss_q.delete(); done_q.delete();
    tick(1'b1, 3, 30, 30, 1'b0);
    tick(1'b1, 0, 20, 25, 1'b0);
    idle(2 * GAP + 1);
    s0 = cyc;
    repeat (10) tick(1'b0, 0, 0, 0, 1'b1);
    idle(6 * GAP + LAT + 10);
    n = 0;
    foreach (iss_q[i]) if (iss_q[i].c > s0 && iss_q[i].c <= s0 + 10) n++;
    chk("stall_no_issue", 32'(n), 0);
    check_thread_seq("stall_seq", 0, 20, 6);
    i3 = last_issue_cyc(3);
    d3 = done_cyc_of(3);
    chk("stall_drain_lat", 32'(d3 - i3), LAT);
    chk("stall_drain_spans_stall", 32'(i3 < s0 && d3 > s0 + 10), 1);
    $display("stall window=%0d thr0 issues checked", s0);

    // Reset while threads 0 and 3 are running: no done pulse and no issue afterwards.
    tick(1'b1, 0, 0, 200, 1'b0);
    tick(1'b1, 3, 0, 200, 1'b0);
    idle(2 * GAP + 2);
    do_reset();
    iss_q.delete(); done_q.delete();
    idle(LAT + 20);
    chk("post_reset_done", 32'(done_q.size()), 0);
    chk("post_reset_issue", 32'(iss_q.size()), 0);
    chk("post_reset_busy", 32'(busy), 0);
    $display("reset abort issues=%0d dones=%0d", iss_q.size(), done_q.size());

    // Random traffic checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      int th, sp, ep;
      logic s, st;
      s  = ($urandom_range(0, 3) == 0);
      th = $urandom_range(0, N_THR - 1);
      sp = $urandom_range(0, (1 << PC_W) - 1);
      if ($urandom_range(0, 15) == 0) ep = $urandom_range(0, (1 << PC_W) - 1);
      else                            ep = (sp + $urandom_range(0, 5)) % (1 << PC_W);
      st = ($urandom_range(0, 5) == 0);
      tick(s, th, sp, ep, st);
    end
    $display("random phase done cyc=%0d", cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
